// File: rtl/xriscv_rf_pkg.sv
// xriscv_rf_pkg: shared register-file select encoding and switch FSM states.
package xriscv_rf_pkg;

    typedef enum logic {
        MPSCM        = 1'b0,
        ORIGINAL_REG = 1'b1
    } reg_file_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_WAKE,
        S_COPY,
        S_VERIFY,
        S_SWITCH,
        S_RELEASE
    } switch_state_t;

    localparam reg_file_t RF_RESET_SEL = ORIGINAL_REG;

endpackage

// File: rtl/xriscv_regfile_switch_ctrl_if.sv
// xriscv_regfile_switch_ctrl_if: copy-path port between switch controller and regfile mux.
// XRF_SWITCH_VERIFY_EN adds the destination read-back data.
interface xriscv_regfile_switch_ctrl_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  cp_active_o;
    logic [ADDR_WIDTH-1:0] cp_raddr_o;
    logic [DATA_WIDTH-1:0] cp_rdata_i;
    logic [ADDR_WIDTH-1:0] cp_waddr_o;
    logic [DATA_WIDTH-1:0] cp_wdata_o;
    logic                  cp_we_o;
`ifdef XRF_SWITCH_VERIFY_EN
    logic [DATA_WIDTH-1:0] cp_rdata_dst_i;
`endif

    modport master (
        output cp_active_o, cp_raddr_o, cp_waddr_o, cp_wdata_o, cp_we_o,
`ifdef XRF_SWITCH_VERIFY_EN
        input  cp_rdata_dst_i,
`endif
        input  cp_rdata_i
    );

    modport slave (
        input  cp_active_o, cp_raddr_o, cp_waddr_o, cp_wdata_o, cp_we_o,
`ifdef XRF_SWITCH_VERIFY_EN
        output cp_rdata_dst_i,
`endif
        output cp_rdata_i
    );
endinterface

// File: rtl/xriscv_rf_copy_seq.sv
// xriscv_rf_copy_seq: walks register addresses 1..2^ADDR_WIDTH-1, one per cycle.
module xriscv_rf_copy_seq #(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  last_o,
    output logic                  busy_o
);
    localparam logic [ADDR_WIDTH-1:0] FIRST = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] LAST  = '1;

    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    // Restart wins over stepping; after LAST the counter parks at FIRST so x0 is never addressed.
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            cnt_d  = FIRST;
            busy_d = 1'b1;
        end else if (busy_q) begin
            busy_d = cnt_q != LAST;
            cnt_d  = (cnt_q == LAST) ? FIRST : cnt_q + FIRST;
        end
    end

    // Counter and busy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= FIRST;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign addr_o = cnt_q;
    assign last_o = busy_q && cnt_q == LAST;
    assign busy_o = busy_q;
endmodule

// File: rtl/xriscv_regfile_switch_ctrl.sv
// xriscv_regfile_switch_ctrl: run-time MPSCM/ORIGINAL_REG switch with state copy.
// XRF_SWITCH_VERIFY_EN inserts a read-back verify pass; a mismatch keeps the old file.
module xriscv_regfile_switch_ctrl
    import xriscv_rf_pkg::*;
#(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic switch_req_i,
    input  logic target_sel_i,
    output logic stall_req_o,
    input  logic stall_ack_i,
    output logic reg_mux_o,
    output logic cg_en_mpscm_o,
    output logic cg_en_orig_o,
    output logic busy_o,
    output logic done_o,
    output logic err_o,
`ifdef XRF_SWITCH_VERIFY_EN
    output logic verify_fail_o,
`endif
    xriscv_regfile_switch_ctrl_if.master cp
);
    switch_state_t         state_q, state_d;
    reg_file_t             tgt_q, tgt_d, mux_q, mux_d;
    logic [1:0]            cg_q, cg_d;
    logic [3:0]            settle_q, settle_d;
    logic                  err_q, err_d, noop_q, noop_d;
    logic                  seq_start, seq_last, seq_busy, flip_ok;
    logic [ADDR_WIDTH-1:0] seq_addr;

    xriscv_rf_copy_seq #(.ADDR_WIDTH(ADDR_WIDTH)) u_seq (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (seq_start),
        .addr_o  (seq_addr),
        .last_o  (seq_last),
        .busy_o  (seq_busy)
    );

`ifdef XRF_SWITCH_VERIFY_EN
    logic mism_q, vfail_q, cmp_fail;
    assign cmp_fail = state_q == S_VERIFY && cp.cp_rdata_i != cp.cp_rdata_dst_i;
    // Per-switch mismatch decides the flip; the sticky copy is what software sees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mism_q  <= 1'b0;
            vfail_q <= 1'b0;
        end else begin
            mism_q  <= (state_q == S_COPY) ? 1'b0 : (mism_q | cmp_fail);
            vfail_q <= vfail_q | cmp_fail;
        end
    end
    assign flip_ok       = !mism_q;
    assign verify_fail_o = vfail_q;
`else
    assign flip_ok = 1'b1;
`endif

    // Next-state logic; the select and clock gates only change in registered form.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        mux_d     = mux_q;
        cg_d      = cg_q;
        settle_d  = settle_q;
        noop_d    = 1'b0;
        seq_start = 1'b0;
        err_d     = err_q | (!stall_ack_i && (state_q == S_WAKE || state_q == S_COPY ||
                                              state_q == S_VERIFY || state_q == S_SWITCH));
        case (state_q)
            S_IDLE: if (switch_req_i) begin
                if (reg_file_t'(target_sel_i) == mux_q) begin
                    noop_d = 1'b1;
                end else begin
                    tgt_d   = reg_file_t'(target_sel_i);
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: if (stall_ack_i) begin
                cg_d[tgt_q] = 1'b1;
                settle_d    = 4'd0;
                state_d     = S_WAKE;
            end
            S_WAKE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
                    seq_start = 1'b1;
                    state_d   = S_COPY;
                end
            end
            S_COPY: if (seq_last) begin
`ifdef XRF_SWITCH_VERIFY_EN
                seq_start = 1'b1;
                state_d   = S_VERIFY;
`else
                state_d   = S_SWITCH;
`endif
            end
`ifdef XRF_SWITCH_VERIFY_EN
            S_VERIFY: if (seq_last) state_d = S_SWITCH;
`endif
            S_SWITCH: begin
                if (flip_ok) mux_d = tgt_q;
                else cg_d[tgt_q] = 1'b0;
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                if (mux_q == tgt_q) cg_d[~tgt_q] = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset lands on ORIGINAL_REG with only its clock running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            tgt_q    <= RF_RESET_SEL;
            mux_q    <= RF_RESET_SEL;
            cg_q     <= 2'b01 << RF_RESET_SEL;
            settle_q <= 4'd0;
            err_q    <= 1'b0;
            noop_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            mux_q    <= mux_d;
            cg_q     <= cg_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            noop_q   <= noop_d;
        end
    end

    assign stall_req_o    = state_q != S_IDLE;
    assign busy_o         = state_q != S_IDLE || noop_q;
    assign done_o         = state_q == S_RELEASE || noop_q;
    assign err_o          = err_q;
    assign reg_mux_o      = mux_q;
    assign cg_en_mpscm_o  = cg_q[MPSCM];
    assign cg_en_orig_o   = cg_q[ORIGINAL_REG];
    assign cp.cp_active_o = state_q == S_WAKE || state_q == S_COPY ||
                            state_q == S_VERIFY || state_q == S_SWITCH;
    assign cp.cp_raddr_o  = (state_q == S_COPY || state_q == S_VERIFY) ? seq_addr : '0;
    assign cp.cp_waddr_o  = (state_q == S_COPY) ? seq_addr : '0;
    assign cp.cp_wdata_o  = (state_q == S_COPY) ? cp.cp_rdata_i : {DATA_WIDTH{1'b0}};
    assign cp.cp_we_o     = state_q == S_COPY && seq_busy;
endmodule

// File: tb/tb_xriscv_regfile_switch_ctrl.sv
// tb_xriscv_regfile_switch_ctrl: directed/randomized switches checked against a register-file model.
module tb_xriscv_regfile_switch_ctrl;
    import xriscv_rf_pkg::*;

    localparam int AW     = 5;
    localparam int DW     = 32;
    localparam int SETTLE = 2;
    localparam int NREG   = (1 << AW) - 1;
`ifdef XRF_SWITCH_VERIFY_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    logic clk = 1'b0, rst_n = 1'b0, switch_req = 1'b0, target_sel = 1'b0, stall_ack = 1'b0;
    logic stall_req, reg_mux, cg_mpscm, cg_orig, busy, done, err;
`ifdef XRF_SWITCH_VERIFY_EN
    logic verify_fail;
`endif
    logic          corrupt = 1'b0;
    logic [DW-1:0] rf [2][NREG+1];
    int            tests = 0, fails = 0;
    int            done_c, done_n, busy_n, stall_n, we_n, bad_w;
    logic          mux_at_done;
    logic [1:0]    cg_at_done;
    int            d;

    always #5 clk = ~clk;

    xriscv_regfile_switch_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cp ();

    assign cp.cp_rdata_i = rf[reg_mux][cp.cp_raddr_o];
`ifdef XRF_SWITCH_VERIFY_EN
    assign cp.cp_rdata_dst_i = rf[!reg_mux][cp.cp_raddr_o] ^
                               DW'(corrupt && cp.cp_raddr_o == AW'(7));
`endif

    xriscv_regfile_switch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SETTLE_CYCLES(SETTLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .switch_req_i  (switch_req),
        .target_sel_i  (target_sel),
        .stall_req_o   (stall_req),
        .stall_ack_i   (stall_ack),
        .reg_mux_o     (reg_mux),
        .cg_en_mpscm_o (cg_mpscm),
        .cg_en_orig_o  (cg_orig),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
`ifdef XRF_SWITCH_VERIFY_EN
        .verify_fail_o (verify_fail),
`endif
        .cp            (cp)
    );

    function automatic int exp_lat(input int drain);
        return 1 + drain + SETTLE + PASSES * NREG + 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_mux"}, reg_mux, 1);
        chk({tag, "_cg_orig"}, cg_orig, 1);
        chk({tag, "_cg_mpscm"}, cg_mpscm, 0);
        chk({tag, "_stall"}, stall_req, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_active"}, cp.cp_active_o, 0);
        chk({tag, "_we"}, cp.cp_we_o, 0);
        chk({tag, "_waddr"}, 32'(cp.cp_waddr_o), 0);
        chk({tag, "_raddr"}, 32'(cp.cp_raddr_o), 0);
        chk({tag, "_wdata"}, cp.cp_wdata_o, 0);
`ifdef XRF_SWITCH_VERIFY_EN
        chk({tag, "_vfail"}, verify_fail, 0);
`endif
    endtask

    task automatic fill(input int f, input bit rnd);
        for (int i = 0; i <= NREG; i++) rf[f][i] = rnd ? $urandom : 32'hA5A5_0000 + 32'(i);
    endtask

    // Cycle 1 carries the request; the core acks after stall_req has been seen for 'drain' cycles.
    task automatic run_switch(input logic tgt, input int drain, input int req2_c,
                              input int drop_c, input int rst_addr);
        int            stall_cnt = 0;
        int            wi = 0;
        logic          src;
        logic [DW-1:0] snap [NREG+1];
        src = reg_mux;
        for (int i = 0; i <= NREG; i++) snap[i] = rf[src][i];
        done_c = 0; done_n = 0; busy_n = 0; stall_n = 0; we_n = 0; bad_w = 0;
        mux_at_done = 1'bx; cg_at_done = 2'bxx;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            switch_req = (c == 1) || (c == req2_c);
            target_sel = (c == 1) ? tgt : !tgt;
            stall_cnt  = stall_req ? stall_cnt + 1 : 0;
            stall_ack  = stall_cnt >= drain && c != drop_c;
            #1;
            if (stall_req) stall_n++;
            if (busy) busy_n++;
            if (cp.cp_we_o) begin
                we_n++;
                wi++;
                if (wi > NREG || int'(cp.cp_waddr_o) != wi || cp.cp_wdata_o !== snap[wi]) bad_w++;
                rf[!src][cp.cp_waddr_o] = cp.cp_wdata_o;
                if (int'(cp.cp_waddr_o) == rst_addr) begin
                    rst_n = 1'b0;
                    #1;
                    chk_reset("midrst");
                    @(negedge clk);
                    rst_n = 1'b1;
                    break;
                end
            end
            if (done) begin
                done_n++;
                if (done_c == 0) begin
                    done_c      = c;
                    mux_at_done = reg_mux;
                    cg_at_done  = {cg_orig, cg_mpscm};
                end
            end
            if (done_c != 0 && c >= done_c + 3) break;
        end
        switch_req = 1'b0;
        stall_ack  = 1'b0;
    endtask

    initial begin
        fill(1, 0);
        fill(0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk_reset("rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset("idle");

        // Request the file already selected: immediate done, nothing else moves.
        run_switch(1'b1, 3, 0, 0, -1);
        chk("noop_done_c", done_c, 2);
        chk("noop_done_n", done_n, 1);
        chk("noop_stall", stall_n, 0);
        chk("noop_we", we_n, 0);
        chk("noop_busy", busy_n, 1);
        chk("noop_mux", reg_mux, 1);

        // ORIG -> MPSCM with the pattern preload and a 3-cycle drain.
        run_switch(1'b0, 3, 0, 0, -1);
        chk("t1_latency", done_c, exp_lat(3));
        chk("t1_done_n", done_n, 1);
        chk("t1_writes", we_n, NREG);
        chk("t1_bad_w", bad_w, 0);
        chk("t1_mux_at_done", mux_at_done, 0);
        chk("t1_cg_at_done", cg_at_done, 2'b11);
        chk("t1_cg_orig", cg_orig, 0);
        chk("t1_cg_mpscm", cg_mpscm, 1);
        chk("t1_stall", stall_req, 0);
        chk("t1_busy", busy, 0);
        chk("t1_err", err, 0);

        // Back to ORIG over random data; a second request during COPY must be dropped.
        fill(1, 1);
        d = $urandom_range(1, 5);
        run_switch(1'b1, d, 1 + d + SETTLE + 5, 0, -1);
        chk("t2_latency", done_c, exp_lat(d));
        chk("t2_done_n", done_n, 1);
        chk("t2_bad_w", bad_w, 0);
        chk("t2_mux", reg_mux, 1);
        chk("t2_cg_orig", cg_orig, 1);
        chk("t2_cg_mpscm", cg_mpscm, 0);

        // Ack glitch mid-COPY: sticky error, sequence still finishes.
        fill(0, 1);
        d = $urandom_range(1, 5);
        chk("t3_err_pre", err, 0);
        run_switch(1'b0, d, 0, 1 + d + SETTLE + 10, -1);
        chk("t3_err", err, 1);
        chk("t3_latency", done_c, exp_lat(d));
        chk("t3_done_n", done_n, 1);
        chk("t3_mux", reg_mux, 0);
        chk("t3_bad_w", bad_w, 0);

        fill(1, 1);
        run_switch(1'b1, $urandom_range(1, 5), 0, 0, -1);
        chk("t4_err_sticky", err, 1);
        chk("t4_mux", reg_mux, 1);
        chk("t4_bad_w", bad_w, 0);

        // Reset when copy address 12 is on the bus.
        fill(0, 1);
        run_switch(1'b0, 2, 0, 0, 12);
        chk("t5_done_n", done_n, 0);
        chk("t5_err", err, 0);
        chk("t5_mux", reg_mux, 1);

        fill(0, 1);
        d = $urandom_range(1, 5);
        run_switch(1'b0, d, 0, 0, -1);
        chk("t6_latency", done_c, exp_lat(d));
        chk("t6_bad_w", bad_w, 0);
        chk("t6_mux", reg_mux, 0);

`ifdef XRF_SWITCH_VERIFY_EN
        // Corrupted destination x7: no flip, destination clock off, source kept.
        fill(1, 1);
        corrupt = 1'b1;
        run_switch(1'b1, 2, 0, 0, -1);
        corrupt = 1'b0;
        chk("t7_vfail", verify_fail, 1);
        chk("t7_mux_at_done", mux_at_done, 0);
        chk("t7_mux", reg_mux, 0);
        chk("t7_done_n", done_n, 1);
        chk("t7_latency", done_c, exp_lat(2));
        chk("t7_cg_orig", cg_orig, 0);
        chk("t7_cg_mpscm", cg_mpscm, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
